// File: rtl/systolic_output_drain.sv
// Drain stage behind the systolic array accumulators: per-column requantize,
// vector FIFO, then a valid/ready stream of OUT_LANES columns per beat.

module systolic_requant_lane #(
  parameter int ACC_W       = 32,
  parameter int PMAX        = 8,
  parameter int SHIFT_WIDTH = 5
) (
  input  logic [ACC_W-1:0]       x,
  input  logic [SHIFT_WIDTH-1:0] shift,
  input  logic                   relu,
  output logic [PMAX-1:0]        q
);
  localparam logic signed [ACC_W:0] QMAX = $signed({{(ACC_W-PMAX+2){1'b0}}, {(PMAX-1){1'b1}}});
  localparam logic signed [ACC_W:0] QMIN = ~QMAX;

  logic        [ACC_W:0] rnd;
  logic signed [ACC_W:0] sum, shr, rl;

  // One extra bit of headroom so the rounding add cannot wrap.
  always_comb begin
    rnd = '0;
    if (shift != '0) rnd = (ACC_W+1)'(1) << (shift - 1'b1);
    sum = $signed({x[ACC_W-1], x}) + $signed(rnd);
    shr = sum >>> shift;
    rl  = (relu && shr < 0) ? '0 : shr;
    if (rl > QMAX)      q = QMAX[PMAX-1:0];
    else if (rl < QMIN) q = QMIN[PMAX-1:0];
    else                q = rl[PMAX-1:0];
  end
endmodule

module systolic_output_drain #(
  parameter int ARRAY_M           = 2,
  parameter int PMAX              = 8,
  parameter int ACCUMULATOR_WIDTH = 4*PMAX,
  parameter int OUT_LANES         = 1,
  parameter int FIFO_DEPTH        = 4,
  parameter int SHIFT_WIDTH       = 5
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic [SHIFT_WIDTH-1:0]               cfg_shift,
  input  logic                                 cfg_relu,
  input  logic                                 in_valid,
  input  logic [ARRAY_M*ACCUMULATOR_WIDTH-1:0] in_data,
  output logic                                 out_valid,
  input  logic                                 out_ready,
  output logic [OUT_LANES*PMAX-1:0]            out_data,
  output logic                                 out_last,
  output logic [$clog2(FIFO_DEPTH):0]          fifo_count,
  output logic                                 overflow,
  input  logic                                 err_clear
);
  localparam int ACC_W = ACCUMULATOR_WIDTH;
  localparam int BEATS = ARRAY_M / OUT_LANES;
  localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int PW    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW    = $clog2(FIFO_DEPTH) + 1;
  localparam int LW    = OUT_LANES * PMAX;

  logic [ARRAY_M-1:0][PMAX-1:0] q_comb, q_vec;
  logic                         q_valid;

  logic [BEATS-1:0][LW-1:0] mem [FIFO_DEPTH];
  logic [BEATS-1:0][LW-1:0] head;
  logic [PW-1:0]            wr_ptr, rd_ptr;
  logic [CW-1:0]            count;
  logic [BW-1:0]            beat;
  logic                     at_last, xfer, pop, push, drop;

  for (genvar i = 0; i < ARRAY_M; i++) begin : g_lane
    systolic_requant_lane #(.ACC_W(ACC_W), .PMAX(PMAX), .SHIFT_WIDTH(SHIFT_WIDTH)) u_lane (
      .x     (in_data[i*ACC_W +: ACC_W]),
      .shift (cfg_shift),
      .relu  (cfg_relu),
      .q     (q_comb[i])
    );
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q_valid <= 1'b0;
      q_vec   <= '0;
    end else begin
      q_valid <= in_valid;
      if (in_valid) q_vec <= q_comb;
    end
  end

  assign out_valid  = (count != '0);
  assign at_last    = (beat == BW'(BEATS-1));
  assign xfer       = out_valid && out_ready;
  assign pop        = xfer && at_last;
  // A full FIFO still takes the write when the head leaves in the same cycle.
  assign push       = q_valid && ((count < CW'(FIFO_DEPTH)) || pop);
  assign drop       = q_valid && !push;
  assign head       = mem[rd_ptr];
  assign out_data   = out_valid ? head[beat] : '0;
  assign out_last   = out_valid && at_last;
  assign fifo_count = count;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= q_vec;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      beat     <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (xfer) beat <= at_last ? '0 : beat + 1'b1;
      if (drop)           overflow <= 1'b1;
      else if (err_clear) overflow <= 1'b0;
    end
  end
endmodule

// File: tb/tb_systolic_output_drain.sv
// Directed bench for systolic_output_drain at PMAX=8, ARRAY_M=2, ACC_W=32, one lane, depth 4.

module tb_systolic_output_drain;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [4:0]  cfg_shift = '0;
  logic        cfg_relu = 1'b0;
  logic        in_valid = 1'b0;
  logic [63:0] in_data = '0;
  logic        out_valid, out_ready = 1'b0, out_last, overflow, err_clear = 1'b0;
  logic [7:0]  out_data;
  logic [2:0]  fifo_count;

  int checks = 0;
  int failures = 0;

  systolic_output_drain dut (
    .clk(clk), .reset(reset), .cfg_shift(cfg_shift), .cfg_relu(cfg_relu),
    .in_valid(in_valid), .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_last(out_last), .fifo_count(fifo_count),
    .overflow(overflow), .err_clear(err_clear)
  );

  always #5 clk = ~clk;

  // Called on a falling edge; presents one vector for exactly one rising edge.
  task automatic drive_vec(input int c0, input int c1, input int sh, input bit rl);
    in_data = {c1, c0}; cfg_shift = 5'(sh); cfg_relu = rl; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
    checks++; if (out_last !== 1'b0) begin failures++; $display("FAIL reset_last got=%b exp=0", out_last); end
    checks++; if (fifo_count !== 3'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", fifo_count); end
    checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL reset_overflow got=%b exp=0", overflow); end
    checks++; if (out_data !== 8'h00) begin failures++; $display("FAIL reset_data got=%h exp=00", out_data); end
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic;
    out_ready = 1'b1;
    drive_vec(100, -300, 2, 0);
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL basic_latency got=%b exp=0", out_valid); end
    @(negedge clk);
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL basic_valid got=%b exp=1", out_valid); end
    checks++; if (out_data !== 8'h19) begin failures++; $display("FAIL basic_beat0 got=%h exp=19", out_data); end
    checks++; if (out_last !== 1'b0) begin failures++; $display("FAIL basic_last0 got=%b exp=0", out_last); end
    @(negedge clk);
    checks++; if (out_data !== 8'hB5) begin failures++; $display("FAIL basic_beat1 got=%h exp=b5", out_data); end
    checks++; if (out_last !== 1'b1) begin failures++; $display("FAIL basic_last1 got=%b exp=1", out_last); end
    @(negedge clk);
    checks++; if (fifo_count !== 3'd0) begin failures++; $display("FAIL basic_count got=%0d exp=0", fifo_count); end
  endtask

  task automatic test_saturate_relu;
    logic [7:0] exp0 [2];
    logic [7:0] exp1 [2];
    exp0[0] = 8'h7F; exp1[0] = 8'h80;
    exp0[1] = 8'h7F; exp1[1] = 8'h00;
    out_ready = 1'b1;
    for (int r = 0; r < 2; r++) begin
      drive_vec(1000, -1000, 0, r[0]);
      @(negedge clk);
      checks++; if (out_data !== exp0[r]) begin failures++; $display("FAIL sat_relu%0d_beat0 got=%h exp=%h", r, out_data, exp0[r]); end
      @(negedge clk);
      checks++; if (out_data !== exp1[r]) begin failures++; $display("FAIL sat_relu%0d_beat1 got=%h exp=%h", r, out_data, exp1[r]); end
      @(negedge clk);
    end
  endtask

  task automatic test_overflow;
    logic [7:0] expd;
    out_ready = 1'b0;
    cfg_shift = '0; cfg_relu = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      in_data = {32'(k + 10), 32'(k)}; in_valid = 1'b1;
      @(negedge clk);
    end
    in_valid = 1'b0;
    @(negedge clk);
    checks++; if (fifo_count !== 3'd4) begin failures++; $display("FAIL ovf_count got=%0d exp=4", fifo_count); end
    checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL ovf_flag got=%b exp=1", overflow); end
    out_ready = 1'b1;
    for (int b = 0; b < 8; b++) begin
      expd = (b % 2) ? 8'(b/2 + 11) : 8'(b/2 + 1);
      checks++; if (out_data !== expd || out_last !== 1'(b % 2))
        begin failures++; $display("FAIL ovf_drain%0d got=%h/%b exp=%h/%b", b, out_data, out_last, expd, 1'(b % 2)); end
      @(negedge clk);
    end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL ovf_fifth_absent got=%b exp=0", out_valid); end
    checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL ovf_sticky got=%b exp=1", overflow); end
    err_clear = 1'b1;
    @(negedge clk);
    err_clear = 1'b0;
    checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL ovf_clear got=%b exp=0", overflow); end
  endtask

  task automatic test_full_pop;
    logic [7:0] expd [8];
    expd = '{8'd22, 8'd32, 8'd23, 8'd33, 8'd24, 8'd34, 8'd50, 8'd60};
    out_ready = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      in_data = {32'(k + 30), 32'(k + 20)}; in_valid = 1'b1;
      @(negedge clk);
    end
    in_valid = 1'b0;
    @(negedge clk);
    checks++; if (fifo_count !== 3'd4) begin failures++; $display("FAIL full_count got=%0d exp=4", fifo_count); end
    // Beat 0 leaves now; the last beat leaves on the same edge as the stage-2 write.
    out_ready = 1'b1;
    in_data = {32'd60, 32'd50}; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    checks++; if (out_last !== 1'b1) begin failures++; $display("FAIL full_last got=%b exp=1", out_last); end
    @(negedge clk);
    checks++; if (fifo_count !== 3'd4) begin failures++; $display("FAIL full_pop_count got=%0d exp=4", fifo_count); end
    checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL full_pop_ovf got=%b exp=0", overflow); end
    for (int b = 0; b < 8; b++) begin
      checks++; if (out_data !== expd[b]) begin failures++; $display("FAIL full_drain%0d got=%h exp=%h", b, out_data, expd[b]); end
      @(negedge clk);
    end
    checks++; if (fifo_count !== 3'd0) begin failures++; $display("FAIL full_empty got=%0d exp=0", fifo_count); end
  endtask

  task automatic test_reset_mid;
    out_ready = 1'b1;
    drive_vec(5, 6, 0, 0);
    @(negedge clk);
    checks++; if (out_data !== 8'd5) begin failures++; $display("FAIL mid_beat0 got=%h exp=05", out_data); end
    @(negedge clk);
    reset = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL mid_valid got=%b exp=0", out_valid); end
    checks++; if (fifo_count !== 3'd0) begin failures++; $display("FAIL mid_count got=%0d exp=0", fifo_count); end
    checks++; if (out_last !== 1'b0) begin failures++; $display("FAIL mid_last got=%b exp=0", out_last); end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    drive_vec(7, 8, 0, 0);
    @(negedge clk);
    checks++; if (out_data !== 8'd7 || out_last !== 1'b0) begin failures++; $display("FAIL mid_restart0 got=%h/%b exp=07/0", out_data, out_last); end
    @(negedge clk);
    checks++; if (out_data !== 8'd8 || out_last !== 1'b1) begin failures++; $display("FAIL mid_restart1 got=%h/%b exp=08/1", out_data, out_last); end
    @(negedge clk);
  endtask

  initial begin
    test_reset;
    test_basic;
    test_saturate_relu;
    test_overflow;
    test_full_pop;
    test_reset_mid;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
